// File: rtl/inst_buffer.sv
//==============================================================================
// Module   : inst_buffer
// Purpose  : Instruction buffer between Fetch and Dispatch. Circular FIFO of
//            fetch packets. Accepts up to N packets per cycle and presents the
//            oldest up to N packets in program order. Flushed by restore_valid.
// Ports    : clock, reset               - clock, async active-high reset
//            inst_buffer_inputs          - N packets from Fetch, slot 0 oldest
//            instructions_valid          - number of valid input packets
//            inst_buffer_spots           - free slots advertised to Fetch
//            restore_valid               - flush all contents
//            dispatch_band_width         - packets consumed by Dispatch
//            inst_buffer_outputs         - oldest packets, slot 0 oldest
//            outputs_valid               - number of valid output packets
// Options  : INST_BUFFER_BYPASS_EN - same-cycle forwarding of input packets
//            to empty output slots (default: disabled, 1-cycle latency).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module inst_buffer #(
  parameter int N               = 2,
  parameter int DEPTH           = 8,
  parameter int PKT_W           = 33,
  parameter int NUM_SCALAR_BITS = $clog2(N + 1)
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [N-1:0][PKT_W-1:0]        inst_buffer_inputs,
  input  logic [NUM_SCALAR_BITS-1:0]     instructions_valid,
  output logic [NUM_SCALAR_BITS-1:0]     inst_buffer_spots,
  input  logic                           restore_valid,
  input  logic [NUM_SCALAR_BITS-1:0]     dispatch_band_width,
  output logic [N-1:0][PKT_W-1:0]        inst_buffer_outputs,
  output logic [NUM_SCALAR_BITS-1:0]     outputs_valid
);

  localparam int c_pw = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_cw = $clog2(DEPTH + 1);
  localparam int c_nw = (N > 1) ? $clog2(N) : 1;

  logic [c_pw-1:0]  head_q, head_d;
  logic [c_pw-1:0]  tail_q, tail_d;
  logic [c_cw-1:0]  count_q, count_d;
  logic [PKT_W-1:0] mem_q [DEPTH];
  logic [PKT_W-1:0] mem_d [DEPTH];

  int w_count;  // start-of-cycle occupancy
  int w_vis;    // entries visible from the array, min(count, N)
  int w_spots;  // free slots offered to Fetch
  int w_k;      // packets accepted this cycle
  int w_ov;     // valid output slots
  int w_d;      // packets popped this cycle
  int w_byp;    // popped packets that came straight from the inputs

  // Per-cycle counts
  always_comb begin
    w_count = int'(count_q);
    w_vis   = (w_count < N) ? w_count : N;
    w_spots = ((DEPTH - w_count) < N) ? (DEPTH - w_count) : N;
    // Excess instructions_valid is clamped; flush ignores the enqueue
    if (restore_valid) begin
      w_k = 0;
    end else begin
      w_k = (int'(instructions_valid) < w_spots) ? int'(instructions_valid) : w_spots;
    end
`ifdef INST_BUFFER_BYPASS_EN
    w_ov  = ((w_count + w_k) < N) ? (w_count + w_k) : N;
`else
    w_ov  = w_vis;
`endif
    w_d   = (int'(dispatch_band_width) < w_ov) ? int'(dispatch_band_width) : w_ov;
`ifdef INST_BUFFER_BYPASS_EN
    // Pops beyond the stored entries are served by forwarded inputs
    w_byp = (w_d > w_count) ? (w_d - w_count) : 0;
`else
    w_byp = 0;
`endif
  end

  // Output slots: stored entries first, then (bypass only) forwarded inputs
  always_comb begin
    for (int i = 0; i < N; i++) begin
      inst_buffer_outputs[i] = '0;
      if (i < w_vis) begin
        inst_buffer_outputs[i] = mem_q[c_pw'(int'(head_q) + i)];
      end
`ifdef INST_BUFFER_BYPASS_EN
      else if (i < w_ov) begin
        inst_buffer_outputs[i] = inst_buffer_inputs[c_nw'(i - w_count)];
      end
`endif
    end
    outputs_valid     = NUM_SCALAR_BITS'(w_ov);
    inst_buffer_spots = NUM_SCALAR_BITS'(w_spots);
  end

  // Next state. Forwarded-and-consumed packets are never written, so both
  // pointers skip them; the count change is k - d either way.
  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q + c_pw'(w_d - w_byp);
    tail_d  = tail_q + c_pw'(w_k - w_byp);
    count_d = c_cw'(w_count + w_k - w_d);
    for (int i = 0; i < N; i++) begin
      if ((i >= w_byp) && (i < w_k)) begin
        mem_d[c_pw'(int'(tail_q) + i - w_byp)] = inst_buffer_inputs[i];
      end
    end
    if (restore_valid) begin
      mem_d   = mem_q;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      mem_q   <= mem_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_inst_buffer.sv
//==============================================================================
// Module   : tb_inst_buffer
// Purpose  : Self-checking bench for inst_buffer (N=2, DEPTH=8, 33-bit
//            packets = {taken, pc[31:0]}).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_inst_buffer;

  logic             clock;
  logic             reset;
  logic [1:0][32:0] inputs;
  logic [1:0]       iv;
  logic [1:0]       spots;
  logic             restore;
  logic [1:0]       dbw;
  logic [1:0][32:0] outputs;
  logic [1:0]       ov;

  int checks = 0;
  int errors = 0;

  inst_buffer #(.N(2), .DEPTH(8), .PKT_W(33)) dut (
    .clock               (clock),
    .reset               (reset),
    .inst_buffer_inputs  (inputs),
    .instructions_valid  (iv),
    .inst_buffer_spots   (spots),
    .restore_valid       (restore),
    .dispatch_band_width (dbw),
    .inst_buffer_outputs (outputs),
    .outputs_valid       (ov)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [32:0] pk(input int idx);
    logic [31:0] pc;
    pc = 32'(idx * 4);
    return {1'(idx % 2), pc};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] v, input logic [1:0] b, input logic r,
                       input logic [32:0] a0, input logic [32:0] a1);
    iv = v; dbw = b; restore = r; inputs[0] = a0; inputs[1] = a1;
  endtask

  task automatic idle();
    drive(2'd0, 2'd0, 1'b0, '0, '0);
  endtask

  // Apply one cycle of inputs, clock, then quiet the inputs
  task automatic cycle(input logic [1:0] v, input logic [1:0] b, input logic r,
                       input logic [32:0] a0, input logic [32:0] a1);
    drive(v, b, r, a0, a1);
    @(posedge clock); #1;
    idle();
    #1;
  endtask

  typedef struct {
    logic [1:0]  iv;
    logic [1:0]  dbw;
    logic [32:0] in0;
    logic [32:0] in1;
    logic [1:0]  e_spots;
    logic [1:0]  e_ov;
    logic [32:0] e_o0;
    logic [32:0] e_o1;
  } vec_t;

  vec_t vecs[10];
  logic [32:0] q[$];

  initial begin
    // Fill, partial accept, pop at full, wrap of both pointers, drain
    vecs[0] = '{2'd2, 2'd0, pk(0),  pk(1),  2'd2, 2'd2, pk(0),  pk(1)};
    vecs[1] = '{2'd2, 2'd0, pk(2),  pk(3),  2'd2, 2'd2, pk(0),  pk(1)};
    vecs[2] = '{2'd2, 2'd1, pk(4),  pk(5),  2'd2, 2'd2, pk(1),  pk(2)};
    vecs[3] = '{2'd2, 2'd0, pk(6),  pk(7),  2'd1, 2'd2, pk(1),  pk(2)};
    vecs[4] = '{2'd2, 2'd0, pk(8),  pk(9),  2'd0, 2'd2, pk(1),  pk(2)};
    vecs[5] = '{2'd2, 2'd2, pk(20), pk(21), 2'd2, 2'd2, pk(3),  pk(4)};
    vecs[6] = '{2'd0, 2'd2, '0,     '0,     2'd2, 2'd2, pk(5),  pk(6)};
    vecs[7] = '{2'd1, 2'd2, pk(10), pk(22), 2'd2, 2'd2, pk(7),  pk(8)};
    vecs[8] = '{2'd0, 2'd2, '0,     '0,     2'd2, 2'd1, pk(10), '0};
    vecs[9] = '{2'd0, 2'd1, '0,     '0,     2'd2, 2'd0, '0,     '0};

    reset = 1'b1;
    idle();
    repeat (2) @(posedge clock);
    #3 reset = 1'b0;
    @(posedge clock); #1;

    chk("reset_spots", 64'(spots), 64'd2);
    chk("reset_ov",    64'(ov),    64'd0);
    chk("reset_out",   64'(outputs), 64'd0);

    // ---------------- table-driven vectors ----------------
    for (int i = 0; i < 10; i++) begin
      cycle(vecs[i].iv, vecs[i].dbw, 1'b0, vecs[i].in0, vecs[i].in1);
      chk($sformatf("vec%0d_spots", i), 64'(spots),      64'(vecs[i].e_spots));
      chk($sformatf("vec%0d_ov", i),    64'(ov),         64'(vecs[i].e_ov));
      chk($sformatf("vec%0d_out0", i),  64'(outputs[0]), 64'(vecs[i].e_o0));
      chk($sformatf("vec%0d_out1", i),  64'(outputs[1]), 64'(vecs[i].e_o1));
    end

    // ---------------- flush ----------------
    cycle(2'd2, 2'd0, 1'b0, pk(30), pk(31));
    cycle(2'd2, 2'd0, 1'b0, pk(32), pk(33));
    cycle(2'd2, 2'd0, 1'b0, pk(34), pk(35));
    drive(2'd2, 2'd0, 1'b1, pk(36), pk(37));
    #1;
    chk("flush_cycle_out0", 64'(outputs[0]), 64'(pk(30)));
    @(posedge clock); #1;
    idle(); #1;
    chk("flush_ov",    64'(ov),    64'd0);
    chk("flush_spots", 64'(spots), 64'd2);
    cycle(2'd1, 2'd0, 1'b0, {1'b0, 32'h100}, '0);
    chk("flush_push_ov",   64'(ov),         64'd1);
    chk("flush_push_out0", 64'(outputs[0]), 64'({1'b0, 32'h100}));
    chk("flush_push_out1", 64'(outputs[1]), 64'd0);
    cycle(2'd0, 2'd1, 1'b0, '0, '0);
    chk("flush_drain_ov", 64'(ov), 64'd0);

    // ---------------- fill to full, overflow drop, pop at full ----------------
    for (int i = 0; i < 4; i++) cycle(2'd2, 2'd0, 1'b0, pk(40 + 2*i), pk(41 + 2*i));
    chk("full_spots", 64'(spots), 64'd0);
    cycle(2'd2, 2'd0, 1'b0, pk(60), pk(61));
    chk("overflow_spots", 64'(spots), 64'd0);
    chk("overflow_out0",  64'(outputs[0]), 64'(pk(40)));
    drive(2'd2, 2'd2, 1'b0, pk(62), pk(63));
    #1;
    chk("pushpop_full_spots_same", 64'(spots), 64'd0);
    @(posedge clock); #1;
    idle(); #1;
    chk("pushpop_full_spots_next", 64'(spots), 64'd2);
    chk("pushpop_full_out0", 64'(outputs[0]), 64'(pk(42)));
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("drain%0d_out0", i), 64'(outputs[0]), 64'(pk(42 + 2*i)));
      chk($sformatf("drain%0d_out1", i), 64'(outputs[1]), 64'(pk(43 + 2*i)));
      cycle(2'd0, 2'd2, 1'b0, '0, '0);
    end
    chk("drain_empty_ov", 64'(ov), 64'd0);

    // ---------------- bypass vs. registered latency ----------------
    drive(2'd2, 2'd2, 1'b0, pk(70), pk(71));
    #1;
`ifdef INST_BUFFER_BYPASS_EN
    chk("byp_same_ov",   64'(ov),         64'd2);
    chk("byp_same_out0", 64'(outputs[0]), 64'(pk(70)));
    @(posedge clock); #1;
    idle(); #1;
    chk("byp_next_ov", 64'(ov), 64'd0);
`else
    chk("byp_same_ov", 64'(ov), 64'd0);
    @(posedge clock); #1;
    idle(); #1;
    chk("byp_next_ov",   64'(ov),         64'd2);
    chk("byp_next_out1", 64'(outputs[1]), 64'(pk(71)));
    cycle(2'd0, 2'd2, 1'b0, '0, '0);
`endif

    // ---------------- wrap-around stream with a scoreboard ----------------
    begin
      int sent;
      int cyc;
      int k;
      int d;
      int sp;
      int nv;
      sent = 0;
      cyc  = 0;
      q.delete();
      while ((sent < 16 || q.size() > 0) && cyc < 40) begin
        k = (16 - sent >= 2) ? 2 : 16 - sent;
        drive(2'(k), (cyc >= 2) ? 2'd2 : 2'd0, 1'b0,
              (k > 0) ? {1'(sent[0] ^ sent[2]), 32'(sent * 4)} : 33'd0,
              (k > 1) ? {1'(sent[0] ^ sent[2] ^ 1), 32'((sent + 1) * 4)} : 33'd0);
        #1;
        nv = (q.size() < 2) ? q.size() : 2;
        chk($sformatf("wrap%0d_ov", cyc), 64'(ov), 64'(nv));
        if (nv > 0) chk($sformatf("wrap%0d_out0", cyc), 64'(outputs[0]), 64'(q[0]));
        if (nv > 1) chk($sformatf("wrap%0d_out1", cyc), 64'(outputs[1]), 64'(q[1]));
        // model update
        sp = (8 - q.size() < 2) ? 8 - q.size() : 2;
        if (k > sp) k = sp;
        d = (cyc >= 2) ? ((nv < 2) ? nv : 2) : 0;
        for (int j = 0; j < d; j++) void'(q.pop_front());
        for (int j = 0; j < k; j++) begin
          q.push_back({1'((sent + j) % 2 ^ ((sent + j) / 4) % 2), 32'((sent + j) * 4)});
        end
        sent += k;
        @(posedge clock); #1;
        cyc++;
      end
      idle(); #1;
      chk("wrap_done_in_budget", 64'(cyc < 40), 64'd1);
      chk("wrap_final_ov", 64'(ov), 64'd0);
    end

    // ---------------- asynchronous reset with count=5 ----------------
    cycle(2'd2, 2'd0, 1'b0, pk(80), pk(81));
    cycle(2'd2, 2'd0, 1'b0, pk(82), pk(83));
    cycle(2'd1, 2'd0, 1'b0, pk(84), '0);
    chk("pre_reset_ov", 64'(ov), 64'd2);
    reset = 1'b1;
    #1;
    chk("async_reset_ov",    64'(ov),      64'd0);
    chk("async_reset_out",   64'(outputs), 64'd0);
    chk("async_reset_spots", 64'(spots),   64'd2);
    reset = 1'b0;
    @(posedge clock); #1;
    chk("post_reset_ov", 64'(ov), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/inst_buffer.md
# inst_buffer

Instruction buffer between Fetch and Dispatch: a circular FIFO of FETCH_PACKET entries that accepts up to N packets per cycle from Fetch and presents the oldest up to N packets to Dispatch in program order. It advertises free space to Fetch through `inst_buffer_spots`, which Fetch uses in the same cycle to decide how many packets to send. It is flushed on branch-misprediction recovery (`restore_valid`).

## Interface
- `N`, `` `N ``: superscalar width; per-cycle maximum for enqueue and dequeue.
- `DEPTH`, 8: number of entries; power of two, at least N.
- `NUM_SCALAR_BITS`, `` `NUM_SCALAR_BITS `` ($clog2(N+1)): width of all per-cycle counts.
- `clock`  in  1  the single clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `inst_buffer_inputs`  in  N x FETCH_PACKET  packets from Fetch; slot 0 is the oldest.
- `instructions_valid`  in  NUM_SCALAR_BITS  number of valid packets, taken from slots 0..k-1.
- `inst_buffer_spots`  out  NUM_SCALAR_BITS  min(DEPTH - count, N); combinational from registered state.
- `restore_valid`  in  1  flush; discards all entries and this cycle's enqueue.
- `dispatch_band_width`  in  NUM_SCALAR_BITS  number of output packets Dispatch consumes this cycle.
- `inst_buffer_outputs`  out  N x FETCH_PACKET  oldest entries; slot 0 is the oldest; invalid slots are zero.
- `outputs_valid`  out  NUM_SCALAR_BITS  min(count, N), or a larger value with bypass (see Configuration).

## Operation
- State:
  - `head` and `tail` pointers, each $clog2(DEPTH) bits, wrapping modulo DEPTH.
  - `count`, $clog2(DEPTH+1) bits.
  - entry array of DEPTH x FETCH_PACKET.
- Enqueue:
  - accepted k = min(instructions_valid, inst_buffer_spots).
  - input slot i is written to entry (tail+i) mod DEPTH, for i < k.
  - tail advances by k.
  - An excess `instructions_valid` is a Fetch protocol error; the block silently clamps it and does not overflow.
- Dequeue:
  - popped d = min(dispatch_band_width, outputs_valid).
  - head advances by d.
  - output slot i is entry (head+i) mod DEPTH for i < outputs_valid; otherwise '0.
- Count update: count_next = count + k - d. It never exceeds DEPTH and never goes below 0.
- `inst_buffer_spots` uses the start-of-cycle count. Same-cycle pops do not free spots for Fetch until the next cycle. This is deliberately conservative and breaks the comb loop through Dispatch.
- Simultaneous enqueue and dequeue are always permitted, including when count == DEPTH (pop only) and count == 0 (push only).
- Flush (`restore_valid`=1):
  - next state is head=tail=count=0.
  - enqueue and dequeue are ignored.
  - outputs in the flush cycle still show pre-flush contents; Dispatch must ignore them.
  - Flush dominates all other inputs.
- Reset:
  - head=tail=count=0.
  - `outputs_valid`=0, `inst_buffer_outputs`='0, `inst_buffer_spots`=min(DEPTH,N).
  - Assertion mid-operation drops all contents asynchronously.

## Timing
- Enqueue-to-visible latency is 1 cycle: a packet written at edge t appears on `inst_buffer_outputs` after edge t, unless bypass is enabled.
- Dequeue takes effect at the next edge; the outputs shift then.
- `inst_buffer_spots` and `outputs_valid` are pure functions of registered state (bypass excepted) and are stable for the whole cycle.
- Throughput is N in and N out per cycle in steady state when DEPTH ≥ 2N.

## Configuration
- `INST_BUFFER_BYPASS_EN`: enables same-cycle forwarding.
  - Defined: output slots count..N-1 are filled combinationally from input slots 0..k-1, and outputs_valid = min(count + k, N).
  - Defined: incoming packets that are consumed in the same cycle are never written to the array; tail advances only by the unconsumed remainder.
  - Defined: `restore_valid` suppresses bypass.
  - Not defined: no combinational path from `inst_buffer_inputs`/`instructions_valid` to outputs; 1-cycle latency as above.

## Test plan
- Reset: assert `reset` mid-run with count=5 (N=2, DEPTH=8) -> count=0, outputs_valid=0, outputs all zero, inst_buffer_spots=2, with no clock edge needed.
- Fill to full: 4 cycles of instructions_valid=2, dispatch_band_width=0 -> count=8, inst_buffer_spots=0. A 5th push of 2 is dropped and count stays 8.
- Wrap-around: push PCs 0x00..0x3C (16 packets) while popping 2 per cycle after a 2-cycle lag -> outputs emerge in exact PC order across pointer wrap, with taken bits preserved.
- Simultaneous push/pop at full: count=8, instructions_valid=2, dispatch_band_width=2 -> spots=0, so 0 accepted and count=6. Next cycle spots=2.
- Flush: count=6 with restore_valid=1 and instructions_valid=2 -> count=0 next cycle; the following push of PC 0x100 appears as output slot 0.
- Bypass (macro defined): empty buffer, push 2 packets with dispatch_band_width=2 -> outputs_valid=2 in the same cycle and count stays 0. Without the macro: outputs_valid=0 that cycle and 2 the next.
